// File: rtl/noise_mem_array.sv
// noise_mem_array: pCHANNELS x pBANKS small RAMs holding LFSR-derived masking noise.
// An internal Galois LFSR and a fill/refresh sequencer generate every write; each
// channel offers two registered read ports (a, b) sharing one bank select.
// Parameter limits: pWIDTH >= 16, pBANKS <= 256, pCHANNELS <= 255.
module noise_mem_array #(
   parameter int unsigned pWIDTH     = 32,
   parameter int unsigned pADDR_BITS = 3,
   parameter int unsigned pBANKS     = 16,
   parameter int unsigned pCHANNELS  = 3,
   parameter logic [31:0] pLFSR_TAPS = 32'h80200003
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              I_seed_load,
   input  logic [pWIDTH-1:0]                 I_seed,
   input  logic                              I_start,
   input  logic                              I_mode,
   input  logic [pBANKS-1:0]                 I_enable,
   input  logic                              I_stop,
   input  logic                              I_rd_valid,
   input  logic [7:0]                        I_rd_bank,
   input  logic [pCHANNELS*pADDR_BITS-1:0]   I_rd_addr_a,
   input  logic [pCHANNELS*pADDR_BITS-1:0]   I_rd_addr_b,
   output logic [pCHANNELS*pWIDTH-1:0]       O_rd_data_a,
   output logic [pCHANNELS*pWIDTH-1:0]       O_rd_data_b,
   output logic                              O_rd_valid,
   output logic                              O_busy,
   output logic                              O_ready,
   output logic                              O_done,
   output logic [pWIDTH-1:0]                 O_lfsr_state
);

   localparam int unsigned Depth   = 2 ** pADDR_BITS;
   localparam int unsigned TagBits = pWIDTH - 8;
   localparam int unsigned TagReps = (TagBits + pADDR_BITS - 1) / pADDR_BITS;
   localparam int unsigned RepBits = TagReps * pADDR_BITS;

   localparam logic [pWIDTH-1:0]     Taps     = pWIDTH'(pLFSR_TAPS);
   localparam logic [pADDR_BITS-1:0] AddrLast = '1;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StReady,
      StRefresh
   } state_e;

   state_e                          state_q, state_d;
   logic [pWIDTH-1:0]               lfsr_q, lfsr_d;
   logic [pADDR_BITS-1:0]           addr_q, addr_d;
   logic [pBANKS-1:0]               en_q, en_d;
   logic                            mode_q, mode_d;
   logic                            stop_q, stop_d;
   logic                            busy_q, busy_d;
   logic                            ready_q, ready_d;
   logic                            done_q, done_d;
   logic                            rd_valid_q, rd_valid_d;
   logic [pCHANNELS*pWIDTH-1:0]     rd_data_a_q, rd_data_a_d;
   logic [pCHANNELS*pWIDTH-1:0]     rd_data_b_q, rd_data_b_d;

   logic [pWIDTH-1:0]               lfsr_step;
   logic [pWIDTH-1:0]               seed_eff;
   logic                            wr_active;
   logic [RepBits-1:0]              addr_rep;

   // Asynchronous per-bank read data, muxed by bank select before the output registers
   logic [pWIDTH-1:0]               bank_rd_a [pCHANNELS][pBANKS];
   logic [pWIDTH-1:0]               bank_rd_b [pCHANNELS][pBANKS];

   // LFSR next value, seed sanitising and write qualification
   always_comb begin
      lfsr_step = {1'b0, lfsr_q[pWIDTH-1:1]} ^ (lfsr_q[0] ? Taps : '0);
      // An all-zero seed would lock the LFSR, so it is replaced by 1
      seed_eff  = (I_seed == '0) ? pWIDTH'(1) : I_seed;
      wr_active = (state_q == StFill) || (state_q == StRefresh);
   end

   // Address replicated MSB-first; the tag keeps its top TagBits bits
   assign addr_rep = {TagReps{addr_q}};

   for (genvar c = 0; c < pCHANNELS; c++) begin : g_ch
      logic [pWIDTH-1:0] tag;

      assign tag = {8'(c + 1), addr_rep[RepBits-1 -: TagBits]};

      for (genvar k = 0; k < pBANKS; k++) begin : g_bank
         logic [pWIDTH-1:0] mem_q [Depth];
         logic [pWIDTH-1:0] wdata;

         assign wdata = lfsr_q ^ tag ^ pWIDTH'(k);

         // Single write port, no reset so the array infers as RAM
         always_ff @(posedge clk) begin
            if (wr_active && en_q[k]) begin
               mem_q[addr_q] <= wdata;
            end
         end

         // Two read ports; registering happens after the bank mux (read-first)
         assign bank_rd_a[c][k] = mem_q[I_rd_addr_a[c*pADDR_BITS +: pADDR_BITS]];
         assign bank_rd_b[c][k] = mem_q[I_rd_addr_b[c*pADDR_BITS +: pADDR_BITS]];
      end
   end

   // Sequencer next state: seed/start handling, fill and refresh address walk
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      addr_d  = addr_q;
      en_d    = en_q;
      mode_d  = mode_q;
      stop_d  = stop_q;
      busy_d  = busy_q;
      ready_d = ready_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle, StReady: begin
            if (I_seed_load) begin
               lfsr_d = seed_eff;
            end
            if (I_start) begin
               state_d = StFill;
               en_d    = I_enable;
               mode_d  = I_mode;
               addr_d  = '0;
               stop_d  = 1'b0;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end
         end

         StFill: begin
            lfsr_d = lfsr_step;
            addr_d = addr_q + 1'b1;
            if (addr_q == AddrLast) begin
               done_d  = 1'b1;
               ready_d = 1'b1;
               if (mode_q) begin
                  state_d = StRefresh;
               end else begin
                  state_d = StReady;
                  busy_d  = 1'b0;
               end
            end
         end

         StRefresh: begin
            lfsr_d = lfsr_step;
            addr_d = addr_q + 1'b1;
            // Stop request is held until the pass reaches its last address
            if (I_stop) begin
               stop_d = 1'b1;
            end
            if ((addr_q == AddrLast) && (stop_q || I_stop)) begin
               state_d = StReady;
               busy_d  = 1'b0;
               stop_d  = 1'b0;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Read path: bank mux, out-of-range bank reads as zero, hold when idle
   always_comb begin
      rd_valid_d  = I_rd_valid;
      rd_data_a_d = rd_data_a_q;
      rd_data_b_d = rd_data_b_q;
      if (I_rd_valid) begin
         rd_data_a_d = '0;
         rd_data_b_d = '0;
         for (int c = 0; c < pCHANNELS; c++) begin
            for (int k = 0; k < pBANKS; k++) begin
               if (I_rd_bank == 8'(k)) begin
                  rd_data_a_d[c*pWIDTH +: pWIDTH] = bank_rd_a[c][k];
                  rd_data_b_d[c*pWIDTH +: pWIDTH] = bank_rd_b[c][k];
               end
            end
         end
      end
   end

   // State, LFSR and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         lfsr_q      <= pWIDTH'(1);
         addr_q      <= '0;
         en_q        <= '0;
         mode_q      <= 1'b0;
         stop_q      <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         addr_q      <= addr_d;
         en_q        <= en_d;
         mode_q      <= mode_d;
         stop_q      <= stop_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
      end
   end

   assign O_rd_data_a  = rd_data_a_q;
   assign O_rd_data_b  = rd_data_b_q;
   assign O_rd_valid   = rd_valid_q;
   assign O_busy       = busy_q;
   assign O_ready      = ready_q;
   assign O_done       = done_q;
   assign O_lfsr_state = lfsr_q;

endmodule

// File: tb/tb_noise_mem_array.sv
// Self-checking bench for noise_mem_array: directed sequence with random seeds and
// random read addresses, checked against a behavioural model of the memory contents.
module tb_noise_mem_array;

   localparam int W  = 32;
   localparam int AB = 3;
   localparam int NB = 16;
   localparam int NC = 3;
   localparam int D  = 8;
   localparam logic [31:0] TAPS = 32'h80200003;

   logic            clk;
   logic            rst_n;
   logic            I_seed_load;
   logic [W-1:0]    I_seed;
   logic            I_start;
   logic            I_mode;
   logic [NB-1:0]   I_enable;
   logic            I_stop;
   logic            I_rd_valid;
   logic [7:0]      I_rd_bank;
   logic [NC*AB-1:0] I_rd_addr_a;
   logic [NC*AB-1:0] I_rd_addr_b;
   logic [NC*W-1:0] O_rd_data_a;
   logic [NC*W-1:0] O_rd_data_b;
   logic            O_rd_valid;
   logic            O_busy;
   logic            O_ready;
   logic            O_done;
   logic [W-1:0]    O_lfsr_state;

   int checks = 0;
   int errors = 0;

   // Reference contents and reference LFSR
   logic [31:0] mdl [NC][NB][D];
   logic [31:0] m_lfsr;

   noise_mem_array #(
      .pWIDTH     (W),
      .pADDR_BITS (AB),
      .pBANKS     (NB),
      .pCHANNELS  (NC),
      .pLFSR_TAPS (TAPS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .I_seed_load  (I_seed_load),
      .I_seed       (I_seed),
      .I_start      (I_start),
      .I_mode       (I_mode),
      .I_enable     (I_enable),
      .I_stop       (I_stop),
      .I_rd_valid   (I_rd_valid),
      .I_rd_bank    (I_rd_bank),
      .I_rd_addr_a  (I_rd_addr_a),
      .I_rd_addr_b  (I_rd_addr_b),
      .O_rd_data_a  (O_rd_data_a),
      .O_rd_data_b  (O_rd_data_b),
      .O_rd_valid   (O_rd_valid),
      .O_busy       (O_busy),
      .O_ready      (O_ready),
      .O_done       (O_done),
      .O_lfsr_state (O_lfsr_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
   endfunction

   // Channel number in the top byte, address bits repeated MSB-first below it
   function automatic logic [31:0] tag_of(input int c, input int a);
      logic [31:0] t;
      t = 32'(c + 1) << 24;
      for (int i = 0; i < 24; i++) begin
         if (((a >> (2 - (i % 3))) & 1) != 0) t = t | (32'h1 << (23 - i));
      end
      return t;
   endfunction

   function automatic logic [95:0] exp_vec(input int bank, input logic [8:0] aa);
      logic [95:0] v;
      v = '0;
      if (bank >= 0 && bank < NB) begin
         for (int c = 0; c < NC; c++) v[c*32 +: 32] = mdl[c][bank][int'(aa[c*3 +: 3])];
      end
      return v;
   endfunction

   task automatic model_fill(input logic [15:0] en, input int n);
      for (int a = 0; a < n; a++) begin
         for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < NB; k++) begin
               if (en[k]) mdl[c][k][a % D] = m_lfsr ^ tag_of(c, a % D) ^ 32'(k);
            end
         end
         m_lfsr = lfsr_next(m_lfsr);
      end
   endtask

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_fill(input bit load, input logic [31:0] seed, input logic [15:0] en,
                             input bit mode);
      I_seed_load = load;
      I_seed      = seed;
      I_start     = 1'b1;
      I_mode      = mode;
      I_enable    = en;
      if (load) m_lfsr = (seed == 32'h0) ? 32'h1 : seed;
      tick();
      I_seed_load = 1'b0;
      I_start     = 1'b0;
      I_mode      = !mode;
      I_enable    = 16'($urandom);
   endtask

   // Runs until O_busy drops; optional stop pulse and ignored start/seed at given cycles
   task automatic run_busy(input int stop_at, input int ign_at, output int bc, output int dc);
      int cyc;
      bc  = 0;
      dc  = 0;
      cyc = 0;
      if (O_busy) bc++;
      if (O_done) dc++;
      while (O_busy && cyc < 40) begin
         cyc++;
         I_stop = (cyc == stop_at);
         if (cyc == ign_at) begin
            I_start     = 1'b1;
            I_seed_load = 1'b1;
            I_seed      = $urandom;
            I_mode      = 1'b0;
            I_enable    = '0;
         end
         tick();
         I_start     = 1'b0;
         I_seed_load = 1'b0;
         I_stop      = 1'b0;
         if (O_busy) bc++;
         if (O_done) dc++;
      end
   endtask

   task automatic rd(input string tag, input int bank, input logic [8:0] aa, input logic [8:0] ab);
      logic [95:0] ea, eb;
      ea = exp_vec(bank, aa);
      eb = exp_vec(bank, ab);
      I_rd_valid  = 1'b1;
      I_rd_bank   = 8'(bank);
      I_rd_addr_a = aa;
      I_rd_addr_b = ab;
      tick();
      I_rd_valid  = 1'b0;
      I_rd_bank   = 8'($urandom);
      I_rd_addr_a = 9'($urandom);
      I_rd_addr_b = 9'($urandom);
      check({tag, "_vld"}, 96'(O_rd_valid), 96'd1);
      check({tag, "_a"}, O_rd_data_a, ea);
      check({tag, "_b"}, O_rd_data_b, eb);
   endtask

   initial begin
      int          bc, dc;
      logic [31:0] s;
      logic [95:0] eold, enew;

      rst_n       = 1'b1;
      I_seed_load = 1'b0;
      I_seed      = '0;
      I_start     = 1'b0;
      I_mode      = 1'b0;
      I_enable    = '0;
      I_stop      = 1'b0;
      I_rd_valid  = 1'b0;
      I_rd_bank   = '0;
      I_rd_addr_a = '0;
      I_rd_addr_b = '0;
      m_lfsr      = 32'h1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", 96'(O_busy), 96'd0);
      check("rst_ready", 96'(O_ready), 96'd0);
      check("rst_done", 96'(O_done), 96'd0);
      check("rst_vld", 96'(O_rd_valid), 96'd0);
      check("rst_data_a", O_rd_data_a, 96'd0);
      check("rst_data_b", O_rd_data_b, 96'd0);
      check("rst_lfsr", 96'(O_lfsr_state), 96'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Step 1: seed 1, one-shot fill of all banks
      start_fill(1'b1, 32'h1, 16'hFFFF, 1'b0);
      run_busy(0, 0, bc, dc);
      model_fill(16'hFFFF, D);
      check("t1_busy_cycles", 96'(bc), 96'd8);
      check("t1_done_pulses", 96'(dc), 96'd1);
      check("t1_ready", 96'(O_ready), 96'd1);
      check("t1_lfsr", 96'(O_lfsr_state), 96'(m_lfsr));
      rd("t1_b0a0", 0, 9'h0, 9'h0);
      check("t1_b0_ch0", 96'(O_rd_data_a[31:0]), 96'(32'h01000001));
      check("t1_b0_ch2", 96'(O_rd_data_a[95:64]), 96'(32'h03000001));
      tick();
      check("t1_hold_vld", 96'(O_rd_valid), 96'd0);
      check("t1_hold_a", O_rd_data_a, exp_vec(0, 9'h0));
      rd("t1_b5a0", 5, 9'h0, 9'h0);
      check("t1_b5_ch0", 96'(O_rd_data_a[31:0]), 96'(32'h01000004));
      rd("t1_b0a3", 0, {3{3'd3}}, {3{3'd3}});
      s = 32'h1;
      repeat (3) s = lfsr_next(s);
      check("t1_tag_a3", 96'(O_rd_data_a[31:0] ^ s), 96'({8'h01, 24'h6DB6DB}));
      for (int a = 0; a < D; a++) begin
         rd("t1_sweep", $urandom_range(0, NB - 1), {3{3'(a)}}, {3{3'(D - 1 - a)}});
      end

      // Step 2: only bank 0 enabled, new seed 5
      start_fill(1'b1, 32'h5, 16'h0001, 1'b0);
      run_busy(0, 0, bc, dc);
      model_fill(16'h0001, D);
      check("t2_busy_cycles", 96'(bc), 96'd8);
      check("t2_done_pulses", 96'(dc), 96'd1);
      rd("t2_b0", 0, 9'($urandom), 9'($urandom));
      rd("t2_b1", 1, 9'($urandom), 9'($urandom));
      rd("t2_b15", 15, 9'($urandom), 9'($urandom));
      for (int i = 0; i < 8; i++) begin
         rd("t2_rnd", $urandom_range(0, NB - 1), 9'($urandom), 9'($urandom));
      end

      // Zero seed loads as 1
      I_seed_load = 1'b1;
      I_seed      = 32'h0;
      tick();
      I_seed_load = 1'b0;
      m_lfsr      = 32'h1;
      check("seed_zero", 96'(O_lfsr_state), 96'd1);

      // Step 3: fill then refresh; stop at refresh address 3, start ignored at refresh
      s = $urandom;
      start_fill(1'b1, s, 16'hFFFF, 1'b1);
      run_busy(12, 10, bc, dc);
      model_fill(16'hFFFF, 2 * D);
      check("t3_busy_cycles", 96'(bc), 96'd16);
      check("t3_done_pulses", 96'(dc), 96'd1);
      check("t3_busy_end", 96'(O_busy), 96'd0);
      check("t3_ready", 96'(O_ready), 96'd1);
      check("t3_lfsr", 96'(O_lfsr_state), 96'(m_lfsr));
      for (int i = 0; i < 10; i++) begin
         rd("t3_rnd", $urandom_range(0, NB - 1), 9'($urandom), 9'($urandom));
      end

      // Step 4: read-first collision on address 2 during fill
      eold = exp_vec(0, {3{3'd2}});
      start_fill(1'b1, $urandom, 16'hFFFF, 1'b0);
      model_fill(16'hFFFF, D);
      enew = exp_vec(0, {3{3'd2}});
      tick();
      tick();
      I_rd_valid  = 1'b1;
      I_rd_bank   = 8'd0;
      I_rd_addr_a = {3{3'd2}};
      I_rd_addr_b = {3{3'd2}};
      tick();
      check("t4_old_vld", 96'(O_rd_valid), 96'd1);
      check("t4_old_a", O_rd_data_a, eold);
      check("t4_old_b", O_rd_data_b, eold);
      tick();
      I_rd_valid = 1'b0;
      check("t4_new_a", O_rd_data_a, enew);
      check("t4_new_b", O_rd_data_b, enew);
      run_busy(0, 0, bc, dc);
      check("t4_done_pulses", 96'(dc), 96'd1);
      check("t4_lfsr", 96'(O_lfsr_state), 96'(m_lfsr));

      // Step 5: asynchronous reset in the fourth fill cycle
      start_fill(1'b1, $urandom, 16'hFFFF, 1'b0);
      tick();
      tick();
      tick();
      model_fill(16'hFFFF, 3);
      #2 rst_n = 1'b0;
      m_lfsr = 32'h1;
      #1;
      check("t5_busy", 96'(O_busy), 96'd0);
      check("t5_ready", 96'(O_ready), 96'd0);
      check("t5_vld", 96'(O_rd_valid), 96'd0);
      check("t5_data_a", O_rd_data_a, 96'd0);
      check("t5_data_b", O_rd_data_b, 96'd0);
      check("t5_lfsr", 96'(O_lfsr_state), 96'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("t5_ready_after", 96'(O_ready), 96'd0);
      check("t5_busy_after", 96'(O_busy), 96'd0);
      check("t5_lfsr_after", 96'(O_lfsr_state), 96'd1);
      start_fill(1'b0, 32'h0, 16'hFFFF, 1'b0);
      run_busy(0, 0, bc, dc);
      model_fill(16'hFFFF, D);
      check("t5_busy_cycles", 96'(bc), 96'd8);
      check("t5_ready_fill", 96'(O_ready), 96'd1);
      for (int i = 0; i < 8; i++) begin
         rd("t5_rnd", $urandom_range(0, NB - 1), 9'($urandom), 9'($urandom));
      end

      // Step 6: out-of-range bank selects read as zero with valid asserted
      rd("t6_bank20", 20, 9'($urandom), 9'($urandom));
      rd("t6_bank16", 16, 9'($urandom), 9'($urandom));
      rd("t6_bank255", 255, 9'($urandom), 9'($urandom));
      rd("t6_bank15", 15, 9'($urandom), 9'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
